register_file: RTL and testbench

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file.sv | 74 +++++++
 tb/tb_register_file.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// 32 x 32-bit register file with two combinational read ports, one write port
// and a raw debug read port. Register 0 is hard-wired to zero.
// Optional feature: define REGFILE_WRITE_BYPASS_EN to forward same-cycle
// write data onto RD1/RD2. dbg_data always shows the stored value.
module register_file (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [4:0]  A3,
    input  logic [31:0] WD3,
    input  logic        WE3,
    output logic [31:0] RD1,
    output logic [31:0] RD2,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    logic [31:0] regs [32];
    logic        write_en;

    // A write only counts when enabled and not aimed at the zero register.
    assign write_en = WE3 && (A3 != 5'd0);

    // Storage: async clear on reset, otherwise capture WD3 into A3.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (write_en) begin
            regs[A3] <= WD3;
        end
    end

    // Read port 1: zero during reset or for r0, optionally bypassed.
    always_comb begin
        RD1 = '0;
        if (!reset) begin
            if (A1 != 5'd0) begin
                RD1 = regs[A1];
            end
`ifdef REGFILE_WRITE_BYPASS_EN
            if (write_en && (A1 == A3)) begin
                RD1 = WD3;
            end
`endif
        end
    end

    // Read port 2: same behaviour as port 1.
    always_comb begin
        RD2 = '0;
        if (!reset) begin
            if (A2 != 5'd0) begin
                RD2 = regs[A2];
            end
`ifdef REGFILE_WRITE_BYPASS_EN
            if (write_en && (A2 == A3)) begin
                RD2 = WD3;
            end
`endif
        end
    end

    // Debug port: raw stored value, never bypassed.
    always_comb begin
        dbg_data = '0;
        if (!reset && (dbg_addr != 5'd0)) begin
            dbg_data = regs[dbg_addr];
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file. Expected values are queued as stimulus
// is applied and compared once the combinational outputs have settled.
module tb_register_file;

    logic        clk;
    logic        reset;
    logic [4:0]  A1, A2, A3, dbg_addr;
    logic [31:0] WD3;
    logic        WE3;
    logic [31:0] RD1, RD2, dbg_data;

    int checks = 0;
    int errors = 0;

`ifdef REGFILE_WRITE_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    typedef struct {
        string       tag;
        int          port;   // 1 = RD1, 2 = RD2, 3 = dbg_data
        logic [31:0] value;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [32];

    register_file dut (
        .clk      (clk),
        .reset    (reset),
        .A1       (A1),
        .A2       (A2),
        .A3       (A3),
        .WD3      (WD3),
        .WE3      (WE3),
        .RD1      (RD1),
        .RD2      (RD2),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input int port, input logic [31:0] value);
        exp_t e;
        e.tag   = tag;
        e.port  = port;
        e.value = value;
        sb.push_back(e);
    endtask

    // Let combinational outputs settle, then compare every queued expectation.
    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.port)
                1:       obs = RD1;
                2:       obs = RD2;
                default: obs = dbg_data;
            endcase
            check(e.tag, obs, e.value);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0]  a1, a2, a3, da;
        logic [31:0] wd, e1, e2;
        logic        we;

        reset = 1'b1; WE3 = 1'b0; A1 = 5'd5; A2 = 5'd31; A3 = 5'd0;
        WD3 = '0; dbg_addr = 5'd17;
        #2;
        push_exp("rst_rd1", 1, 32'h0);
        push_exp("rst_rd2", 2, 32'h0);
        push_exp("rst_dbg", 3, 32'h0);
        drain();
        tick();
        reset = 1'b0;

        // Write r5, then async reset clears it before any clock edge.
        WE3 = 1'b1; A3 = 5'd5; WD3 = 32'hDEADBEEF;
        tick();
        WE3 = 1'b0; A1 = 5'd5; dbg_addr = 5'd5;
        push_exp("r5_written", 1, 32'hDEADBEEF);
        push_exp("r5_dbg", 3, 32'hDEADBEEF);
        drain();
        reset = 1'b1;
        push_exp("async_rst_rd1", 1, 32'h0);
        push_exp("async_rst_dbg", 3, 32'h0);
        drain();
        reset = 1'b0;
        tick();

        // Register 0 ignores writes.
        WE3 = 1'b1; A3 = 5'd0; WD3 = 32'hFFFFFFFF;
        tick();
        WE3 = 1'b0; A1 = 5'd0; dbg_addr = 5'd0;
        push_exp("r0_rd1", 1, 32'h0);
        push_exp("r0_dbg", 3, 32'h0);
        drain();

        // Basic write, dual read of the same register.
        WE3 = 1'b1; A3 = 5'd8; WD3 = 32'h12345678;
        tick();
        WE3 = 1'b0; A1 = 5'd8; A2 = 5'd8;
        push_exp("dual_rd1", 1, 32'h12345678);
        push_exp("dual_rd2", 2, 32'h12345678);
        drain();

        // Same-cycle read/write on r3.
        WE3 = 1'b1; A3 = 5'd3; WD3 = 32'h1;
        tick();
        A3 = 5'd3; WD3 = 32'h2; A2 = 5'd3; dbg_addr = 5'd3;
        push_exp("rw_same_rd2", 2, Bypass ? 32'h2 : 32'h1);
        push_exp("rw_same_dbg", 3, 32'h1);
        drain();
        tick();
        WE3 = 1'b0;
        push_exp("rw_next_rd2", 2, 32'h2);
        push_exp("rw_next_dbg", 3, 32'h2);
        drain();

        // Write enable low: no effect, including X data.
        WE3 = 1'b0; A3 = 5'd7; WD3 = 32'hAAAA5555;
        tick();
        A3 = 5'd8; WD3 = 'x;
        tick();
        A1 = 5'd7; dbg_addr = 5'd8;
        push_exp("we_low_r7", 1, 32'h0);
        push_exp("we_low_x_r8", 3, 32'h12345678);
        drain();

        // Reset held across a write edge discards the write.
        WE3 = 1'b1; A3 = 5'd9; WD3 = 32'hCAFEF00D; reset = 1'b1;
        tick();
        reset = 1'b0; WE3 = 1'b0; dbg_addr = 5'd9; A1 = 5'd8;
        push_exp("rst_write_r9", 3, 32'h0);
        push_exp("rst_clr_r8", 1, 32'h0);
        drain();

        // First edge after reset release writes again.
        WE3 = 1'b1; A3 = 5'd9; WD3 = 32'h00000055;
        tick();
        WE3 = 1'b0;
        push_exp("resume_r9", 3, 32'h00000055);
        drain();

        for (int i = 0; i < 32; i++) model[i] = '0;
        model[9] = 32'h00000055;

        // Random traffic against a reference array.
        for (int n = 0; n < 40; n++) begin
            a1 = 5'($urandom_range(0, 31));
            a2 = 5'($urandom_range(0, 31));
            a3 = 5'($urandom_range(0, 31));
            da = 5'($urandom_range(0, 31));
            wd = $urandom;
            we = 1'($urandom_range(0, 1));
            if (n % 5 == 0) a1 = a3;
            A1 = a1; A2 = a2; A3 = a3; dbg_addr = da; WD3 = wd; WE3 = we;
            e1 = model[a1];
            e2 = model[a2];
            if (Bypass && we && a3 != 5'd0 && a1 == a3) e1 = wd;
            if (Bypass && we && a3 != 5'd0 && a2 == a3) e2 = wd;
            push_exp("rand_rd1", 1, e1);
            push_exp("rand_rd2", 2, e2);
            push_exp("rand_dbg", 3, model[da]);
            drain();
            tick();
            if (we && a3 != 5'd0) model[a3] = wd;
        end

        WE3 = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
